fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control.sv | 109 ++++++++++
 tb/tb_fetch_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// Instruction fetch sequencer: IDLE/RUN/HALT control of the program counter.
// Issues one instruction per cycle in RUN and parks after a HALT word.
module fetch_control #(
    parameter int AB = 11,
    parameter int DB = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DB-1:0] instr,
    output logic [AB-1:0] pc,
    output logic [4:0]    opcode,
    output logic [AB-1:0] operand,
    output logic          instr_valid,
    output logic          halted,
    output logic [15:0]   run_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        r_state;
    logic [AB-1:0] r_pc;
    logic [4:0]    r_opcode;
    logic [AB-1:0] r_operand;
    logic          r_valid;
    logic          r_halted;
    logic [15:0]   r_run_cycles;

    state_t        w_state_nxt;
    logic [AB-1:0] w_pc_nxt;
    logic [4:0]    w_opcode_nxt;
    logic [AB-1:0] w_operand_nxt;
    logic          w_valid_nxt;
    logic [15:0]   w_run_nxt;
    logic [4:0]    w_op;
    logic [AB-1:0] w_opnd;
    logic [AB-1:0] w_pc_inc;

    assign w_op     = instr[DB-1:DB-5];
    assign w_opnd   = instr[AB-1:0];
    assign w_pc_inc = r_pc + AB'(1);

    // Next-state and fetch decisions; HALT words advance pc but issue nothing.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_opcode_nxt  = r_opcode;
        w_operand_nxt = r_operand;
        w_valid_nxt   = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_pc_nxt = w_pc_inc;
                if (w_op != 5'd0) begin
                    w_opcode_nxt  = w_op;
                    w_operand_nxt = w_opnd;
                    w_valid_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
        endcase
    end

    // Saturating count of cycles spent in RUN, HALT-fetch cycle included.
    always_comb begin
        w_run_nxt = r_run_cycles;
        if (r_state == S_RUN && r_run_cycles != 16'hFFFF) begin
            w_run_nxt = r_run_cycles + 16'd1;
        end
    end

    // State and output registers; reset overrides start and any fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_opcode     <= '0;
            r_operand    <= '0;
            r_valid      <= 1'b0;
            r_halted     <= 1'b1;
            r_run_cycles <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_opcode     <= w_opcode_nxt;
            r_operand    <= w_operand_nxt;
            r_valid      <= w_valid_nxt;
            r_halted     <= (w_state_nxt != S_RUN);
            r_run_cycles <= w_run_nxt;
        end
    end

    assign pc          = r_pc;
    assign opcode      = r_opcode;
    assign operand     = r_operand;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign run_cycles  = r_run_cycles;

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: expected issues are queued by the
// stimulus and popped by a monitor on every instr_valid strobe.
module tb_fetch_control;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] instr;
    logic [10:0] pc;
    logic [4:0]  opcode;
    logic [10:0] operand;
    logic        instr_valid;
    logic        halted;
    logic [15:0] run_cycles;

    typedef struct {
        logic [4:0]  op;
        logic [10:0] opnd;
        logic [10:0] pc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem [0:2047];
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_control dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .pc          (pc),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .halted      (halted),
        .run_cycles  (run_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory reads on the falling edge.
    always @(negedge clk) begin
        instr = mem[pc];
    end

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got op=%0d opnd=%0d pc=%0d, required no strobe",
                         opcode, operand, pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (opcode !== e.op || operand !== e.opnd || pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL strobe: got op=%0d opnd=%0d pc=%0d, required op=%0d opnd=%0d pc=%0d",
                             opcode, operand, pc, e.op, e.opnd, e.pc);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted === 1'b1) break;
        end
        chk("halt_timeout", {31'd0, halted}, 32'd1);
    endtask

    task automatic push(input int op, input int opnd, input int npc);
        exp_t e;
        e.op   = 5'(op);
        e.opnd = 11'(opnd);
        e.pc   = 11'(npc);
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[1] = 16'h0801;
        mem[3] = 16'h1002;

        do_reset();
        chk("rst_pc", {21'd0, pc}, 32'd0);
        chk("rst_opcode", {27'd0, opcode}, 32'd0);
        chk("rst_operand", {21'd0, operand}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_run", {16'd0, run_cycles}, 32'd0);
        tick();
        tick();
        tick();
        chk("idle_pc", {21'd0, pc}, 32'd0);
        chk("idle_halted", {31'd0, halted}, 32'd1);

        pulse();
        chk("run1_halted", {31'd0, halted}, 32'd0);
        wait_halt();
        chk("halt1_pc", {21'd0, pc}, 32'd1);
        chk("halt1_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt1_run", {16'd0, run_cycles}, 32'd1);
        tick();
        tick();
        chk("hold_pc", {21'd0, pc}, 32'd1);
        chk("hold_run", {16'd0, run_cycles}, 32'd1);

        push(1, 1, 2);
        pulse();
        wait_halt();
        chk("halt2_pc", {21'd0, pc}, 32'd3);
        chk("halt2_opcode", {27'd0, opcode}, 32'd1);
        chk("halt2_operand", {21'd0, operand}, 32'd1);
        chk("halt2_run", {16'd0, run_cycles}, 32'd3);

        push(2, 2, 4);
        pulse();
        wait_halt();
        chk("halt3_pc", {21'd0, pc}, 32'd5);
        chk("halt3_opcode", {27'd0, opcode}, 32'd2);
        chk("halt3_operand", {21'd0, operand}, 32'd2);
        chk("halt3_run", {16'd0, run_cycles}, 32'd5);
        chk("prog_q_empty", q.size(), 32'd0);

        for (int i = 0; i < 2048; i++) mem[i] = 16'h0801;
        do_reset();
        for (int k = 0; k < 2050; k++) push(1, 1, (k + 1) % 2048);
        pulse();
        for (int i = 1; i <= 2050; i++) begin
            tick();
            if (i >= 2046 && i <= 2049) begin
                chk("wrap_pc", {21'd0, pc}, i % 2048);
                chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
            end
        end
        chk("wrap_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wrap_rst_pc", {21'd0, pc}, 32'd0);
        chk("wrap_q_empty", q.size(), 32'd0);

        push(1, 1, 1);
        push(1, 1, 2);
        start = 1'b1;
        tick();
        tick();
        tick();
        chk("midrun_pc", {21'd0, pc}, 32'd2);
        reset = 1'b1;
        tick();
        chk("abort_pc", {21'd0, pc}, 32'd0);
        chk("abort_valid", {31'd0, instr_valid}, 32'd0);
        chk("abort_halted", {31'd0, halted}, 32'd1);
        chk("abort_run", {16'd0, run_cycles}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        chk("abort_idle_pc", {21'd0, pc}, 32'd0);
        chk("abort_idle_halted", {31'd0, halted}, 32'd1);
        chk("abort_q_empty", q.size(), 32'd0);

        for (int k = 0; k < 70000; k++) push(1, 1, (k + 1) % 2048);
        pulse();
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 65534) chk("sat_pre", {16'd0, run_cycles}, 32'hFFFE);
            if (i == 65535) chk("sat_hit", {16'd0, run_cycles}, 32'hFFFF);
        end
        chk("sat_end", {16'd0, run_cycles}, 32'hFFFF);
        chk("sat_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("sat_q_empty", q.size(), 32'd0);
        chk("sat_rst_run", {16'd0, run_cycles}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
